// File: rtl/rv32im_types.sv
// rv32im_types: types shared across the RV32IM core.
// Holds the major opcodes the branch predictor decodes and the 2-bit
// saturating counter type, along with the counter's update function.
package rv32im_types;

  // Major opcodes, instruction bits [6:0].
  localparam logic [6:0] op_b_br   = 7'b1100011;
  localparam logic [6:0] op_b_jal  = 7'b1101111;
  localparam logic [6:0] op_b_jalr = 7'b1100111;

  // Two-bit saturating direction counter. The MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_counter_t;

  // Move one step toward the resolved direction, holding at SNT and ST.
  function automatic bp_counter_t bp_counter_next(input bp_counter_t ctr,
                                                  input logic        taken);
    logic [1:0] v;
    v = ctr;
    if (taken) begin
      if (v != 2'b11) v = v + 2'd1;
    end else begin
      if (v != 2'b00) v = v - 2'd1;
    end
    return bp_counter_t'(v);
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// gshare_pht: pattern history table of 2-bit saturating counters.
// One combinational read port (fetch) and one synchronous read-modify-write
// port (commit training).
// Build option: GSHARE_PHT_BYPASS_EN forwards a same-cycle write to the read
// port when both ports address the same entry.
// Ports:
//   clk, rst        clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx_i        fetch index
//   rd_ctr_o        counter at rd_idx_i (combinational)
//   wr_en_i         train the entry at wr_idx_i this cycle
//   wr_idx_i        training index
//   wr_taken_i      resolved direction used for training
module gshare_pht
  import rv32im_types::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bp_counter_t      rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int ENTRIES = 1 << IDX_W;

  bp_counter_t pht_q [ENTRIES];
  bp_counter_t wr_ctr_cur;
  bp_counter_t wr_ctr_d;

  assign wr_ctr_cur = pht_q[wr_idx_i];
  assign wr_ctr_d   = bp_counter_next(wr_ctr_cur, wr_taken_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= WNT;
      end
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= wr_ctr_d;
    end
  end

`ifdef GSHARE_PHT_BYPASS_EN
  // Write-to-read forward: fetch sees the counter value commit is writing.
  assign rd_ctr_o = (wr_en_i && (wr_idx_i == rd_idx_i)) ? wr_ctr_d : pht_q[rd_idx_i];
`else
  // Fetch sees the stored counter; a same-cycle update shows up next cycle.
  assign rd_ctr_o = pht_q[rd_idx_i];
`endif

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history conditional branch direction predictor.
// Fetch index = pc[PHT_INDEX+1:2] ^ zero-extended spec history; commit index
// uses the architectural history as it stood before this cycle's update.
// Build option: GSHARE_PHT_BYPASS_EN (see gshare_pht) forwards a same-cycle
// commit write to the fetch prediction.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_valid     fetch presents pc this cycle
//   pc              fetch PC
//   fetch_is_br     predecoded conditional branch at pc
//   predict_take    direction prediction for pc (combinational)
//   rob_commit      ROB head commits this cycle
//   commit_pc       PC of the committing instruction
//   commit_opcode   opcode of the committing instruction
//   commit_br_take  resolved direction of the committing instruction
//   flush           backend redirect; restore spec history from arch history
//   spec_ghr        speculative global history (registered)
module gshare_predictor
  import rv32im_types::*;
#(
  parameter int PHT_INDEX = 8,
  parameter int GHR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic [31:0]          pc,
  input  logic                 fetch_is_br,
  output logic                 predict_take,
  input  logic                 rob_commit,
  input  logic [31:0]          commit_pc,
  input  logic [6:0]           commit_opcode,
  input  logic                 commit_br_take,
  input  logic                 flush,
  output logic [GHR_WIDTH-1:0] spec_ghr
);

  logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_WIDTH-1:0] arch_ghr_q, arch_ghr_d;
  logic [PHT_INDEX-1:0] fetch_idx;
  logic [PHT_INDEX-1:0] commit_idx;
  logic                 br_commit;
  bp_counter_t          fetch_ctr;
  logic [1:0]           fetch_ctr_bits;

  // Hash: history is zero-extended, so index bits above GHR_WIDTH come
  // straight from the PC.
  for (genvar gi = 0; gi < PHT_INDEX; gi++) begin : g_hash
    if (gi < GHR_WIDTH) begin : g_mix
      assign fetch_idx[gi]  = pc[gi+2] ^ spec_ghr_q[gi];
      assign commit_idx[gi] = commit_pc[gi+2] ^ arch_ghr_q[gi];
    end else begin : g_pass
      assign fetch_idx[gi]  = pc[gi+2];
      assign commit_idx[gi] = commit_pc[gi+2];
    end
  end

  assign br_commit = rob_commit && (commit_opcode == op_b_br);

  gshare_pht #(
    .IDX_W (PHT_INDEX)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (fetch_idx),
    .rd_ctr_o   (fetch_ctr),
    .wr_en_i    (br_commit),
    .wr_idx_i   (commit_idx),
    .wr_taken_i (commit_br_take)
  );

  assign fetch_ctr_bits = fetch_ctr;
  assign predict_take   = !rst && fetch_is_br && fetch_ctr_bits[1];

  always_comb begin
    arch_ghr_d = arch_ghr_q;
    spec_ghr_d = spec_ghr_q;
    if (br_commit) begin
      arch_ghr_d = {arch_ghr_q[GHR_WIDTH-2:0], commit_br_take};
    end
    // Flush restores from the post-commit arch history and overrides any
    // fetch-side shift in the same cycle.
    if (flush) begin
      spec_ghr_d = arch_ghr_d;
    end else if (fetch_valid && fetch_is_br) begin
      spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], predict_take};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

  assign spec_ghr = spec_ghr_q;

  // PC bits outside the index field do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:PHT_INDEX+2], pc[1:0],
                            commit_pc[31:PHT_INDEX+2], commit_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_ALU  = 7'h33;

`ifdef GSHARE_PHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        fetch_is_br;
  logic        predict_take;
  logic        rob_commit;
  logic [31:0] commit_pc;
  logic [6:0]  commit_opcode;
  logic        commit_br_take;
  logic        flush;
  logic [7:0]  spec_ghr;

  gshare_predictor #(
    .PHT_INDEX (8),
    .GHR_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .fetch_is_br    (fetch_is_br),
    .predict_take   (predict_take),
    .rob_commit     (rob_commit),
    .commit_pc      (commit_pc),
    .commit_opcode  (commit_opcode),
    .commit_br_take (commit_br_take),
    .flush          (flush),
    .spec_ghr       (spec_ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] pc;
    logic        fbr;
    logic        rc;
    logic [31:0] cpc;
    logic [6:0]  cop;
    logic        ctk;
    logic        fl;
    logic        exp_pt;
    logic [7:0]  exp_ghr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         n_cmp;
  int         n_fail;

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] p,
                              input logic fbr, input logic rc, input logic [31:0] cpc,
                              input logic [6:0] cop, input logic ctk, input logic fl,
                              input logic ept, input logic [7:0] eghr);
    vec_t v;
    v.rst = r; v.fv = fv; v.pc = p; v.fbr = fbr; v.rc = rc; v.cpc = cpc;
    v.cop = cop; v.ctk = ctk; v.fl = fl; v.exp_pt = ept; v.exp_ghr = eghr;
    return v;
  endfunction

  // Drive one cycle, check the combinational prediction on the falling edge,
  // queue the expected history and compare it just after the rising edge.
  task automatic apply(input vec_t v, input string nm);
    logic [7:0] exp_ghr;
    rst = v.rst; fetch_valid = v.fv; pc = v.pc; fetch_is_br = v.fbr;
    rob_commit = v.rc; commit_pc = v.cpc; commit_opcode = v.cop;
    commit_br_take = v.ctk; flush = v.fl;
    @(negedge clk);
    n_cmp++;
    if (predict_take !== v.exp_pt) begin
      n_fail++;
      $display("FAIL %s predict_take got %0b want %0b", nm, predict_take, v.exp_pt);
    end
    sb_q.push_back(v.exp_ghr);
    @(posedge clk);
    #1;
    exp_ghr = sb_q.pop_front();
    n_cmp++;
    if (spec_ghr !== exp_ghr) begin
      n_fail++;
      $display("FAIL %s spec_ghr got %02h want %02h", nm, spec_ghr, exp_ghr);
    end
    $display("%s: rst=%0b pc=%08h br=%0b commit=%0b op=%02h tk=%0b flush=%0b -> pt=%0b ghr=%02h",
             nm, v.rst, v.pc, v.fbr, v.rc, v.cop, v.ctk, v.fl, predict_take, spec_ghr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  s;
    logic [31:0] p;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1; fetch_valid = 1'b0; pc = '0; fetch_is_br = 1'b0; rob_commit = 1'b0;
    commit_pc = '0; commit_opcode = '0; commit_br_take = 1'b0; flush = 1'b0;

    //              rst fv pc            fbr rc cpc           op       tk fl   pt   ghr
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h00)); // reset
    vecs.push_back(mk(0, 1, 32'h1eceb000, 1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h00)); // reset read
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h010,     OP_BR,   1, 0,   0, 8'h00)); // train idx4 01->10
    vecs.push_back(mk(0, 1, 32'h010,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h01)); // predicts taken
    vecs.push_back(mk(1, 1, 32'h010,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h00)); // mid-op reset forces 0
    vecs.push_back(mk(0, 1, 32'h010,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h00)); // PHT cleared
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h000,     OP_BR,   1, 0,   0, 8'h00)); // idx0 ->10
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h004,     OP_BR,   1, 0,   0, 8'h00)); // idx0 ->11
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h00C,     OP_BR,   1, 0,   0, 8'h00)); // sat 11
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h01C,     OP_BR,   1, 0,   0, 8'h00)); // sat 11
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h03C,     OP_BR,   0, 0,   0, 8'h00)); // 11->10
    vecs.push_back(mk(0, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h01)); // still taken
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0F8,     OP_BR,   0, 0,   0, 8'h01)); // idx20 01->00
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h070,     OP_BR,   0, 0,   0, 8'h01)); // sat 00
    vecs.push_back(mk(0, 1, 32'h084,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h02)); // idx20 not taken
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h160,     OP_BR,   1, 0,   0, 8'h02)); // idx20 00->01
    vecs.push_back(mk(0, 1, 32'h088,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h04)); // still not taken
    vecs.push_back(mk(1, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h00)); // reset again
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,     OP_BR,   1, 0,   0, 8'h00)); // idx80 ->10, A=1
    vecs.push_back(mk(0, 1, 32'h200,      1, 1, 32'h200,     OP_BR,   0, 0,   1, 8'h01)); // idx81 ->00, A=2
    vecs.push_back(mk(0, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h02));
    vecs.push_back(mk(0, 1, 32'h208,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h05)); // S=05 A=02
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h008,     OP_BR,   1, 1,   0, 8'h05)); // flush+commit
    vecs.push_back(mk(0, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h0A));
    vecs.push_back(mk(0, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 1,   0, 8'h05)); // flush beats fetch
    vecs.push_back(mk(0, 1, 32'h014,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h0B)); // flush-cycle train seen
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h000,     OP_JALR, 1, 0,   0, 8'h0B)); // non-branch commits
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h000,     OP_JAL,  1, 0,   0, 8'h0B));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h000,     OP_ALU,  1, 0,   0, 8'h0B));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       OP_ALU,  0, 1,   0, 8'h05)); // arch_ghr untouched
    vecs.push_back(mk(0, 1, 32'h000,      1, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h0A)); // PHT untouched
    vecs.push_back(mk(0, 1, 32'h128,      1, 1, 32'h114,     OP_BR,   1, 0, BYP, {7'h0A, BYP})); // collision
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       OP_ALU,  0, 1,   0, 8'h0B));
    vecs.push_back(mk(0, 1, 32'h12C,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h17)); // update visible
    vecs.push_back(mk(0, 0, 32'h15C,      1, 0, 32'h0,       OP_ALU,  0, 0,   1, 8'h17)); // no fetch_valid
    vecs.push_back(mk(0, 1, 32'h15C,      0, 0, 32'h0,       OP_ALU,  0, 0,   0, 8'h17)); // not a branch

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Stream of predicted-taken fetches at index 0x40 fills the history with
    // ones and must truncate to 8 bits.
    s = 8'h17;
    for (int k = 0; k < 9; k++) begin
      p = {22'd0, (8'h40 ^ s), 2'b00};
      s = {s[6:0], 1'b1};
      apply(mk(0, 1, p, 1, 0, 32'h0, OP_ALU, 0, 0, 1, s), $sformatf("fill%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
